// File: rtl/el_link_fifo.sv
// el_link_fifo: clocked FIFO between two four-phase return-to-zero 1-of-N links.
// Input and output handshakes run as independent FSMs around a circular buffer.
module el_link_fifo #(
  parameter int LINK_WIDTH = 2,
  parameter int RAIL_NUM   = 2,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LINK_WIDTH*RAIL_NUM-1:0] in,
  output logic                           ack_o,
  output logic [LINK_WIDTH*RAIL_NUM-1:0] out,
  input  logic                           ack_i,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           code_err
);
  localparam int W  = LINK_WIDTH * RAIL_NUM;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {IN_WAIT = 1'b0, IN_ACK = 1'b1} in_state_t;
  typedef enum logic [1:0] {OUT_NULL = 2'b00, OUT_DATA = 2'b01, OUT_RTZ = 2'b10} out_state_t;

  function automatic logic digit_null(input logic [RAIL_NUM-1:0] d);
    return (d == {RAIL_NUM{1'b0}});
  endfunction

  function automatic logic digit_valid(input logic [RAIL_NUM-1:0] d);
    return $onehot(d);
  endfunction

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wptr_r, rptr_r;
  logic [CW-1:0] count_r;
  logic [W-1:0]  out_r;
  logic          ack_o_r, code_err_r;
  in_state_t     in_state_r, in_state_next_s;
  out_state_t    out_state_r, out_state_next_s;
  logic          word_valid_s, word_null_s, any_invalid_s;
  logic          write_s, pop_s, load_s;

  // Per-digit completion and code-error classification of the input link
  always_comb begin
    word_valid_s  = 1'b1;
    word_null_s   = 1'b1;
    any_invalid_s = 1'b0;
    for (int d = 0; d < LINK_WIDTH; d++) begin
      word_valid_s  = word_valid_s & digit_valid(in[RAIL_NUM*d +: RAIL_NUM]);
      word_null_s   = word_null_s & digit_null(in[RAIL_NUM*d +: RAIL_NUM]);
      any_invalid_s = any_invalid_s | (~digit_valid(in[RAIL_NUM*d +: RAIL_NUM]) &
                                       ~digit_null(in[RAIL_NUM*d +: RAIL_NUM]));
    end
  end

  // Input handshake next-state; fullness uses the registered count only
  always_comb begin
    in_state_next_s = in_state_r;
    write_s         = 1'b0;
    case (in_state_r)
      IN_WAIT: begin
        if (word_valid_s && (count_r < FULL_COUNT)) begin
          write_s         = 1'b1;
          in_state_next_s = IN_ACK;
        end else begin
          in_state_next_s = IN_WAIT;
        end
      end
      IN_ACK: begin
        if (word_null_s) begin
          in_state_next_s = IN_WAIT;
        end else begin
          in_state_next_s = IN_ACK;
        end
      end
      default: in_state_next_s = IN_WAIT;
    endcase
  end

  // Output handshake next-state; the pop happens on the data-to-RTZ transition
  always_comb begin
    out_state_next_s = out_state_r;
    load_s           = 1'b0;
    pop_s            = 1'b0;
    case (out_state_r)
      OUT_NULL: begin
        if ((count_r != {CW{1'b0}}) && !ack_i) begin
          load_s           = 1'b1;
          out_state_next_s = OUT_DATA;
        end else begin
          out_state_next_s = OUT_NULL;
        end
      end
      OUT_DATA: begin
        if (ack_i) begin
          pop_s            = 1'b1;
          out_state_next_s = OUT_RTZ;
        end else begin
          out_state_next_s = OUT_DATA;
        end
      end
      OUT_RTZ: begin
        if (!ack_i) begin
          out_state_next_s = OUT_NULL;
        end else begin
          out_state_next_s = OUT_RTZ;
        end
      end
      default: out_state_next_s = OUT_NULL;
    endcase
  end

  // Word storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (write_s && !rst) begin
      mem_r[wptr_r] <= in;
    end
  end

  // State, pointers, occupancy and registered link outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_r  <= IN_WAIT;
      out_state_r <= OUT_NULL;
      wptr_r      <= {AW{1'b0}};
      rptr_r      <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      out_r       <= {W{1'b0}};
      ack_o_r     <= 1'b0;
      code_err_r  <= 1'b0;
    end else begin
      in_state_r  <= in_state_next_s;
      out_state_r <= out_state_next_s;
      ack_o_r     <= (in_state_next_s == IN_ACK);
      code_err_r  <= code_err_r | any_invalid_s;
      if (write_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({write_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (load_s) begin
        out_r <= mem_r[rptr_r];
      end else if (pop_s) begin
        out_r <= {W{1'b0}};
      end
    end
  end

  assign ack_o    = ack_o_r;
  assign out      = out_r;
  assign count    = count_r;
  assign code_err = code_err_r;

endmodule

// File: doc/el_link_fifo.md
Name: el_link_fifo

Overview:
- Clocked, parametrised successor to the single-stage delay-insensitive link latch.
- Buffers up to DEPTH words. Each word is LINK_WIDTH digits, and each digit is 1-of-RAIL_NUM encoded.
- Uses a four-phase return-to-zero handshake on both the input and the output link.
- Sits between an async-style link producer and consumer inside the synchronous island. Adds completion detection, code-error detection, an occupancy count and a configurable depth.

Parameters:
- LINK_WIDTH, 2, number of digits per word.
- RAIL_NUM, 2, rails per digit (1-of-N code; 2 = dual-rail).
- DEPTH, 4, buffered words; must be a power of two and at least 2.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in  input  LINK_WIDTH*RAIL_NUM  input link; digit d occupies bits [RAIL_NUM*d+RAIL_NUM-1 : RAIL_NUM*d].
- ack_o  output  1  input-side acknowledge.
- out  output  LINK_WIDTH*RAIL_NUM  output link, same packing as in.
- ack_i  input  1  output-side acknowledge from the consumer.
- count  output  $clog2(DEPTH+1)  number of words stored.
- code_err  output  1  sticky flag: a digit with more than one rail high was seen on in.

Behaviour:
- Reset (synchronous; when rst=1 it overrides everything at the clock edge):
  - ack_o=0, out=all-zero (null), count=0, code_err=0.
  - Both FSMs go to their idle state; read and write pointers go to 0.
- Per-digit classification of in, evaluated combinationally on the current value:
  - null: no rail high.
  - valid: exactly one rail high.
  - invalid: two or more rails high.
  - word_valid: every digit is valid.
  - word_null: every digit is null.
- Input FSM:
  - IN_WAIT (ack_o=0): if word_valid and count<DEPTH, write in at wptr, increment wptr (wraps modulo DEPTH), go to IN_ACK. ack_o=1 from the next cycle.
  - A partially valid word, a full buffer, or any invalid digit holds the FSM in IN_WAIT.
  - IN_ACK (ack_o=1): wait for word_null, then go to IN_WAIT (ack_o=0 next cycle). Any non-null data in IN_ACK is ignored.
  - code_err is set on any cycle where any digit is invalid, in either state. It clears only on rst.
- Output FSM:
  - OUT_NULL (out=0): if count>0 and ack_i=0, go to OUT_DATA. out = word at rptr from the next cycle.
  - OUT_DATA (out=head word, held stable): when ack_i=1, go to OUT_RTZ. out=0 next cycle; rptr increments (wraps) and the word is popped on this transition.
  - OUT_RTZ (out=0): when ack_i=0, go to OUT_NULL.
  - out is registered, so glitch-free data-then-null ordering is guaranteed.
- Latency:
  - ack_o rises 1 cycle after a complete valid word is sampled in IN_WAIT.
  - With an empty buffer and ack_i=0, out carries that word 1 cycle after the write edge, i.e. 2 edges after in became valid.
- count:
  - +1 on a write, -1 on a pop, unchanged when both happen on the same edge.
  - Never exceeds DEPTH and never underflows.
- Full: writes are blocked while count==DEPTH; a pop on the same edge does not unblock that edge's write (the decision uses the registered count).
- Empty: out stays null; an ack_i pulse while in OUT_NULL is ignored.
- rst during an active handshake: all stored words are discarded, ack_o drops to 0 and out drops to null at the same edge. The consumer must re-sync by returning ack_i to 0.
- Dual-rail convention: rail 0 means logic 0, rail 1 means logic 1.

Test Plan:
- Reset with in=4'b1001 and ack_i=1, then release → ack_o=0, out=0, count=0 and code_err=0 during reset. Afterwards in=4'b1001 is captured, since IN_WAIT ignores ack_i.
- Single transfer (LINK_WIDTH=2, RAIL_NUM=2): in=4'b1001, then in=0 after ack_o=1, with ack_i=0 → ack_o=1 one cycle later and out=4'b1001 the next cycle, count=1. Raising ack_i → out=0, count=0. Dropping ack_i → OUT_NULL.
- Fill with ack_i held 0 and consumer stalled: push 4'b0101, 4'b0110, 4'b1001, 4'b1010, then offer 4'b0101 → count=4 and ack_o stays 0 for the fifth word. After one pop, the fifth word is accepted and the output order is 0101, 0110, 1001, 1010, 0101.
- Partial and invalid words: in=4'b0001 (digit 1 null) for 10 cycles → ack_o stays 0 and nothing is written. Then in=4'b0011 → code_err=1 and no write. Then in=4'b1001 → written; code_err stays 1.
- Simultaneous push and pop at count=2 on the same edge → count stays 2 and the pointers wrap correctly across 8 or more transfers with no word lost or duplicated.
- rst asserted during OUT_DATA with count=3 → next cycle out=0, count=0, ack_o=0. A subsequent transfer works normally.
